regfile_sweep: RTL and testbench
================================

REGFILE_SWEEP -- requirements
Module: regfile_sweep

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is 5 bits and fixed.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (asserted when rst=0 at a rising clk edge).
REQ-005 we  input  1  write enable from the write-back stage.
REQ-006 waddr  input  5  write register index.
REQ-007 wdata  input  DATA_W  write data.
REQ-008 re1  input  1  read port 1 enable.
REQ-009 raddr1  input  5  read port 1 index.
REQ-010 rdata1  output  DATA_W  read port 1 data, combinational.
REQ-011 re2  input  1  read port 2 enable.
REQ-012 raddr2  input  5  read port 2 index.
REQ-013 rdata2  output  DATA_W  read port 2 data, combinational.
REQ-014 ready  output  1  registered; high once the clear sweep has completed.

Function
REQ-015 The block SHALL implement a two-state FSM, INIT and RUN, with a 5-bit sweep counter cnt.
REQ-016 In INIT, each rising edge with rst=1 SHALL write zero to reg[cnt] and then increment cnt.
REQ-017 When cnt=NREG-1 in INIT, that edge SHALL clear reg[NREG-1], move to RUN and set ready=1.
REQ-018 ready SHALL therefore rise after exactly 31 rising edges with rst=1 following reset release.
REQ-019 In INIT, we SHALL be ignored, and rdata1/rdata2 SHALL read zero.
REQ-020 In RUN, a rising edge with we=1 and waddr!=0 SHALL write wdata to reg[waddr]; writes to index 0 SHALL be discarded.
REQ-021 RUN SHALL be held until reset; no other transition exists.
REQ-022 rdataN SHALL be zero when reN=0, when raddrN=0, or in INIT.
REQ-023 Otherwise rdataN SHALL be reg[raddrN], subject to REQ-031.
REQ-024 Both read ports SHALL operate independently; identical addresses on both ports SHALL return identical data.
REQ-025 Register 0 SHALL never be written and SHALL always read zero.
REQ-026 Latency: a write is visible on the reads from the cycle after its rising edge (without bypass).

Reset
REQ-027 With rst=0 at a rising edge: state<=INIT, cnt<=1, ready<=0; register contents are not required to change on that edge.
REQ-028 Reset asserted mid-sweep SHALL restart the sweep from cnt=1.
REQ-029 Reset asserted in RUN SHALL drop ready on that edge and perform a full sweep again.
REQ-030 While rst=0, reads SHALL return zero (INIT rule).

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined, in RUN, when we=1, waddr!=0, reN=1 and raddrN=waddr, rdataN SHALL equal wdata in the same cycle (write-to-read forwarding).
REQ-032 Without REGFILE_BYPASS_EN, rdataN SHALL return the stored value (pre-write) in that case; no forwarding logic is compiled.

Verification
REQ-033 Hold rst=0 2 cycles, release -> ready=0 for 30 edges, ready=1 after the 31st edge; pre-sweep garbage in reg[5] reads 0 once ready.
REQ-034 RUN: write 0xDEADBEEF to r7, next cycle re1=1, raddr1=7 -> rdata1=0xDEADBEEF; re1=0 -> rdata1=0.
REQ-035 RUN: we=1, waddr=0, wdata=0xFFFFFFFF, then raddr1=raddr2=0, re1=re2=1 -> both read 0x00000000.
REQ-036 RUN: we=1, waddr=3, wdata=0x12345678 with raddr2=3, re2=1 in the same cycle; r3 previously 0xA5A5A5A5 -> rdata2=0x12345678 with REGFILE_BYPASS_EN, 0xA5A5A5A5 without.
REQ-037 Assert rst=0 at sweep cnt=10 for 1 cycle -> ready stays 0 and rises only 31 edges after re-release.
REQ-038 During INIT, drive we=1, waddr=2, wdata=0x55 -> after ready, r2 reads 0.

Source files
------------

// File: rtl/regfile_sweep.sv
// Register file with a power-on clear sweep and two combinational read ports.
// Ports: clk/rst (sync, active-low); write port we/waddr/wdata; read ports
//   re1/raddr1/rdata1 and re2/raddr2/rdata2; ready flags completion of the clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the reads.
module regfile_sweep #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [4:0] LAST  = 5'(NREG - 1);
  localparam logic [5:0] NREG6 = 6'(NREG);

  state_t            state, state_nx;
  logic [4:0]        cnt, cnt_nx;
  logic              ready_nx;
  logic              clr_en;
  logic              wr_en;
  logic              rd_ok;
  logic [DATA_W-1:0] regs [32];

  // State register; the sweep restarts at 1 because register 0 is hardwired to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= 5'd1;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ready <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready_nx = ready;
    clr_en   = 1'b0;
    wr_en    = 1'b0;
    case (state)
      INIT: begin
        clr_en = 1'b1;
        cnt_nx = cnt + 5'd1;
        if (cnt == LAST) begin
          state_nx = RUN;
          ready_nx = 1'b1;
          cnt_nx   = cnt;
        end
      end
      RUN: begin
        wr_en = we && (waddr != 5'd0) && ({1'b0, waddr} < NREG6);
      end
      default: begin
        state_nx = INIT;
      end
    endcase
  end

  // Array contents are deliberately not reset; the sweep takes care of clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (clr_en) begin
        regs[cnt] <= '0;
      end else if (wr_en) begin
        regs[waddr] <= wdata;
      end
    end
  end

  // Reads are only live in RUN with reset released; anything else returns zero.
  assign rd_ok = (state == RUN) && rst;

  always_comb begin
    rdata1 = '0;
    if (rd_ok && re1 && (raddr1 != 5'd0) && ({1'b0, raddr1} < NREG6)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (raddr1 == waddr)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
`else
      rdata1 = regs[raddr1];
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rd_ok && re2 && (raddr2 != 5'd0) && ({1'b0, raddr2} < NREG6)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (raddr2 == waddr)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
`else
      rdata2 = regs[raddr2];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: vector table, directed corner sequences
// and randomized traffic against a behavioural model of the register file.
module tb_regfile_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ready;

  int total = 0;
  int bad   = 0;

  // Behavioural model: count edges since reset release; registers 1..k are clear after k edges.
  logic [31:0] m_regs [32];
  int          m_edges = 0;
  logic        m_ready = 1'b0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [8];

  regfile_sweep #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra);
    if (!rst || !m_ready || !re || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 5'd0 && waddr == ra) return wdata;
`endif
    return m_regs[ra];
  endfunction

  function automatic void model_update();
    if (!rst) begin
      m_edges = 0;
      m_ready = 1'b0;
    end else if (!m_ready) begin
      m_edges++;
      m_regs[m_edges] = 32'h0;
      if (m_edges == 31) m_ready = 1'b1;
    end else if (we && waddr != 5'd0) begin
      m_regs[waddr] = wdata;
    end
  endfunction

  // Compare outputs against the model mid-cycle, then take one clock edge.
  task automatic step(input string tag);
    #2;
    check({tag, " rdata1"}, rdata1, model_read(re1, raddr1));
    check({tag, " rdata2"}, rdata2, model_read(re2, raddr2));
    check({tag, " ready"}, {31'h0, ready}, {31'h0, m_ready});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd; re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  initial begin
    logic [31:0] exp_byp;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    //                 we  wa     wd            re1 ra1    re2 ra2    e1            e2
    tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7,  1'b0, 5'd7,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b1, 5'd7,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd1,  1'b0, 5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[5] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd7,  1'b0, 5'd3,  32'hDEADBEEF, 32'h0};
    tbl[6] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd3,  1'b0, 5'd31, 32'hA5A5A5A5, 32'h0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd3,  32'h00000001, 32'hA5A5A5A5};

    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check("reset ready", {31'h0, ready}, 32'h0);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd1);
    step("reset hold");

    // Release reset: ready low for 30 edges, high after the 31st.
    rst = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step("sweep");
      check($sformatf("sweep ready e%0d", e), {31'h0, ready}, (e == 31) ? 32'h1 : 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re1, tbl[i].ra1, tbl[i].re2, tbl[i].ra2);
      #2;
      check($sformatf("vec%0d rdata1", i), rdata1, tbl[i].e1);
      check($sformatf("vec%0d rdata2", i), rdata2, tbl[i].e2);
      step("vec");
    end

    // Same-cycle write and read of r3 (holds 0xA5A5A5A5).
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h12345678;
`else
    exp_byp = 32'hA5A5A5A5;
`endif
    set_in(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd3);
    #2;
    check("raw same cycle", rdata2, exp_byp);
    step("raw");
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
    #2;
    check("raw next cycle", rdata1, 32'h12345678);
    step("raw2");

    // Seed r2 and r5 with non-zero data so the re-sweep has something to clear.
    set_in(1'b1, 5'd2, 32'h00000077, 1'b0, 5'd0, 1'b0, 5'd0);
    step("seed2");
    set_in(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd2, 1'b0, 5'd0);
    step("seed5");

    // Reset in RUN drops ready on that edge.
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd2);
    step("run reset");
    check("run reset ready", {31'h0, ready}, 32'h0);

    // Partial sweep to cnt=10, reset for one cycle, with stray writes attempted throughout.
    rst = 1'b1;
    set_in(1'b1, 5'd2, 32'h00000055, 1'b1, 5'd5, 1'b1, 5'd2);
    for (int e = 1; e <= 9; e++) step("partial");
    rst = 1'b0;
    step("mid reset");
    check("mid reset ready", {31'h0, ready}, 32'h0);
    rst = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step("resweep");
      check($sformatf("resweep ready e%0d", e), {31'h0, ready}, (e == 31) ? 32'h1 : 32'h0);
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd5);
    #2;
    check("init write ignored r2", rdata1, 32'h0);
    check("garbage cleared r5", rdata2, 32'h0);
    step("post sweep");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      we = $urandom_range(0, 1);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      re1 = ($urandom_range(0, 3) != 0);
      re2 = ($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
